rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter_pkg.sv | 35 +++
 rtl/rr_mux_arbiter_mux_key.sv | 36 +++
 rtl/rr_mux_arbiter.sv | 107 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg: shared encodings, requester count and the round-robin search helper.
`default_nettype none

package rr_mux_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First requester at or after ptr (mod 4); the descending loop lets the lowest offset win.
  function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    pick_t      p;
    logic [1:0] cand;
    p = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux_arbiter_mux_key.sv
// MuxKey: key-matched lookup mux over a packed {key, data} table; default_out when no key matches.
`default_nettype none

module MuxKey #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2
) (
  output logic [DATA_LEN-1:0]                  out,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [DATA_LEN-1:0]                  default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  key_list  [NR_KEY];
  logic [DATA_LEN-1:0] data_list [NR_KEY];

  generate
    for (genvar n = 0; n < NR_KEY; n++) begin : g_pair
      assign data_list[n] = lut[PAIR_LEN*n +: DATA_LEN];
      assign key_list[n]  = lut[PAIR_LEN*n + DATA_LEN +: KEY_LEN];
    end
  endgenerate

  always_comb begin
    out = default_out;
    for (int n = 0; n < NR_KEY; n++) begin
      if (key == key_list[n]) out = data_list[n];
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: 4-way round-robin arbiter with burst limit, driving a keyed 4:1 data mux.
`default_nettype none

module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int DATA_LEN  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [DATA_LEN-1:0] din0,
  input  logic [DATA_LEN-1:0] din1,
  input  logic [DATA_LEN-1:0] din2,
  input  logic [DATA_LEN-1:0] din3,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] out_data,
  output logic [3:0]          gnt,
  output logic [1:0]          sel,
  output logic                busy
);

  arb_state_t    state, state_nxt;
  logic [1:0]    ptr, ptr_nxt, sel_nxt;
  logic [3:0]    gnt_nxt;
  logic [3:0]    beat, beat_nxt;
  logic          xfer, rel;
  pick_t         pick_idle, pick_rel;
  logic [DATA_LEN-1:0] mux_out;

  assign busy      = (state == GRANT);
  assign out_valid = busy & req[sel];
  assign xfer      = out_valid & out_ready;
  assign rel       = busy & (~req[sel] | (xfer & (beat == 4'(MAX_BURST - 1))));

  assign pick_idle = rr_pick(req, ptr);
  // The releasing requester is masked, so a lone requester is re-granted via one IDLE cycle.
  assign pick_rel  = rr_pick(req & ~gnt, sel + 2'd1);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    beat_nxt  = beat;
    unique case (state)
      IDLE: begin
        if (pick_idle.found) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idle.idx;
          gnt_nxt   = 4'b0001 << pick_idle.idx;
          beat_nxt  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nxt  = sel + 2'd1;
          beat_nxt = '0;
          if (pick_rel.found) begin
            sel_nxt = pick_rel.idx;
            gnt_nxt = 4'b0001 << pick_rel.idx;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (xfer) begin
          beat_nxt = beat + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      gnt   <= '0;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      gnt   <= gnt_nxt;
      beat  <= beat_nxt;
    end
  end

  MuxKey #(
    .NR_KEY  (NUM_REQ),
    .KEY_LEN (2),
    .DATA_LEN(DATA_LEN)
  ) u_mux (
    .out        (mux_out),
    .key        (sel),
    .default_out({DATA_LEN{1'b0}}),
    .lut        ({2'd3, din3, 2'd2, din2, 2'd1, din1, 2'd0, din0})
  );

  assign out_data = (|gnt) ? mux_out : '0;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed vector table plus hand-written burst/reset sequences.
`default_nettype none

module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [1:0] din0, din1, din2, din3;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int nvec = 0;
  int nmis = 0;

  rr_mux_arbiter #(.MAX_BURST(4), .DATA_LEN(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din0     (din0),
    .din1     (din1),
    .din2     (din2),
    .din3     (din3),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [1:0] data;
    logic       busy;
  } vec_t;

  vec_t tbl [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, gnt, sel, out_valid, out_data, busy};
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; out_ready = 1'b0;
    din0 = 2'b01; din1 = 2'b10; din2 = 2'b11; din3 = 2'b10;

    //            rst   req      rdy   gnt      sel   vld   data   busy
    tbl[0]  = '{1'b1, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 2'b11, 1'b1};
    tbl[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 2'b11, 1'b1};
    tbl[3]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 2'b11, 1'b1};
    tbl[4]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 2'b11, 1'b1};
    tbl[5]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 2'b00, 1'b0};
    tbl[6]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 2'b11, 1'b1};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 2'b00, 1'b0};
    tbl[8]  = '{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 2'b01, 1'b1};
    tbl[9]  = '{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 2'b01, 1'b1};
    tbl[10] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 2'b10, 1'b1};

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; out_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d {gnt,sel,vld,data,busy}", i), outs(),
          {22'd0, tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].data, tbl[i].busy});
    end

    // All four requesting: 0,1,2,3,0 with exactly four beats each and no gap.
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("rr_all cyc%0d gnt", i), {28'd0, gnt}, 32'(4'b0001 << ((i / 4) % 4)));
      chk($sformatf("rr_all cyc%0d valid", i), {31'd0, out_valid}, 32'd1);
      step();
    end

    // Stall: grant held while out_ready is low, then exactly four transfers.
    do_reset();
    req = 4'b0010; out_ready = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall cyc%0d gnt", i), {28'd0, gnt}, 32'h2);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall xfer%0d gnt/valid", i), {27'd0, gnt, out_valid}, {27'd0, 4'b0010, 1'b1});
      step();
    end
    chk("stall release gnt", {28'd0, gnt}, 32'h0);

    // Requester 3 drops after two beats: pointer wraps to requester 0.
    do_reset();
    req = 4'b1000; out_ready = 1'b1;
    step();
    chk("wrap gnt3", {28'd0, gnt}, 32'h8);
    step(); step();
    chk("wrap gnt3 after 2", {30'd0, sel}, 32'd3);
    req = 4'b0001;
    #1;
    chk("wrap valid low on drop", {31'd0, out_valid}, 32'd0);
    step();
    chk("wrap gnt0", {28'd0, gnt}, 32'h1);

    // Reset mid-burst of requester 2: one empty cycle, then priority restarts at 0.
    do_reset();
    req = 4'b0100; out_ready = 1'b1;
    step(); step(); step();
    chk("midrst pre gnt", {28'd0, gnt}, 32'h4);
    req = 4'b0110; rst = 1'b1;
    step();
    chk("midrst {gnt,sel,vld,data,busy}", outs(), 32'h0);
    rst = 1'b0;
    step();
    chk("midrst regrant {gnt,sel}", {26'd0, gnt, sel}, {26'd0, 4'b0010, 2'd1});

    // Lone requester 0: re-granted after each 4-beat burst with one low-valid cycle.
    do_reset();
    req = 4'b0001; out_ready = 1'b1;
    step();
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("solo cyc%0d {gnt,valid}", i), {27'd0, gnt, out_valid},
          (i % 5 == 4) ? 32'd0 : {27'd0, 4'b0001, 1'b1});
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
